// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder with programmable latency
//
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready handshake; req_we, req_addr, req_size, req_sext, req_wdata
//   rsp_valid/rsp_ready handshake; rsp_rdata, rsp_err
module dm_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  logic [31:0] mem [DEPTH];

  logic        we_q, sext_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic        accept, rsp_hs, issue, bad;
  logic [AW-1:0] idx;
  logic [4:0]  sh;
  logic [31:0] rd_word, shifted, load_val, mask, merged;

  assign accept = req_valid & req_ready;
  assign rsp_hs = rsp_valid & rsp_ready;
  // RESP is entered one edge before the response is presented; the response
  // (and any store commit) happens on the first RESP edge with rsp_valid low.
  assign issue  = (state == RESP) && !rsp_valid;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = 4'd0;
          state_nx = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAT_LAST) state_nx = RESP;
        else                 cnt_nx   = cnt + 4'd1;
      end
      RESP: begin
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_ready <= (state_nx == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      sext_q  <= req_sext;
      wdata_q <= req_wdata;
    end
  end

  assign bad = (size_q == 2'd3)
             || (size_q == 2'd1 && addr_q[0])
             || (size_q == 2'd2 && addr_q[1:0] != 2'b00)
             || (addr_q >= ADDR_LIMIT);

  assign idx     = addr_q[AW+1:2];
  assign sh      = {addr_q[1:0], 3'b000};
  assign rd_word = mem[idx];
  assign shifted = rd_word >> sh;

  always_comb begin
    load_val = rd_word;
    mask     = 32'hFFFF_FFFF;
    case (size_q)
      2'd0: begin
        load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
        mask     = 32'h0000_00FF << sh;
      end
      2'd1: begin
        load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
        mask     = 32'h0000_FFFF << sh;
      end
      default: begin
        load_val = rd_word;
        mask     = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign merged = (rd_word & ~mask) | ((wdata_q << sh) & mask);

  // Store commit is tied to the response edge so a reset during WAIT drops it.
  always_ff @(posedge clk) begin
    if (reset && issue && we_q && !bad) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (issue) begin
      rsp_valid <= 1'b1;
      rsp_err   <= bad;
      rsp_rdata <= (bad || we_q) ? 32'd0 : load_val;
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
